// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the CPU unified-memory port arbiter.
package cpu_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned LAT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_access_counter.sv
// Access-cycle counter: counts 0..LATENCY-1 and flags the final cycle.
module access_counter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [LAT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == LAT_W'(LATENCY - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory port between instruction fetch and load/store.
// Simultaneous requests alternate; one idle cycle always separates accesses.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t state;
    logic       last_d;
    logic       wr_q;
    logic       in_acc;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       cnt_last;

    assign in_acc  = (state != IDLE);
    assign cnt_inc = in_acc && !cnt_last;
    // Counter sits at zero in IDLE and wraps on the final access cycle.
    assign cnt_clr = !in_acc || cnt_last;

    access_counter #(
        .LATENCY(LATENCY)
    ) u_access_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .last (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            wr_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // On a tie, serve whichever port was not granted last.
                    if (d_req && (!i_req || !last_d)) begin
                        state     <= DACC;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        wr_q      <= d_wr;
                        last_d    <= 1'b1;
                    end else if (i_req) begin
                        state    <= IACC;
                        mem_addr <= i_addr;
                        wr_q     <= 1'b0;
                        last_d   <= 1'b0;
                    end
                end
                IACC: begin
                    if (cnt_last) begin
                        i_rdata <= mem_rdata;
                        state   <= IDLE;
                    end
                end
                DACC: begin
                    if (cnt_last) begin
                        if (!wr_q) begin
                            d_rdata <= mem_rdata;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_en = in_acc;
    assign busy   = in_acc;
    assign i_done = (state == IACC) && cnt_last;
    assign d_done = (state == DACC) && cnt_last;
    assign mem_wr = (state == DACC) && wr_q && cnt_last;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter at LATENCY=4 and LATENCY=1.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_done, d_req, d_wr, d_done, mem_en, mem_wr, busy;
    logic [15:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic        d_req1, i_done1, d_done1, mem_en1, mem_wr1, busy1;
    logic [15:0] d_addr1, i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } exp_t;

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          exp_cycles;
        int          exp_wr_pulses;
    } vec_t;

    exp_t        sb[$];
    logic [15:0] sb1[$];
    logic [15:0] exp_i_rd, exp_d_rd, exp_d_rd1;

    always #5 clk = ~clk;

    function automatic logic [15:0] memword(input logic [15:0] a);
        logic [15:0] w;
        w = {a[7:0], ~a[15:8]} ^ 16'h1357;
        if (a == 16'h0010) w = 16'hA5A5;
        return w;
    endfunction

    assign mem_rdata  = memword(mem_addr);
    assign mem_rdata1 = memword(mem_addr1);

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(1'b0), .i_addr(16'h0000), .i_done(i_done1), .i_rdata(i_rdata1),
        .d_req(d_req1), .d_wr(1'b0), .d_addr(d_addr1), .d_wdata(16'h0000),
        .d_done(d_done1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(output int cycles, output int ens, output int wrs, output bit ok);
        ok = 1'b0; cycles = 0; ens = 0; wrs = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            cycles++;
            if (mem_en) ens++;
            if (mem_wr) begin
                wrs++;
                check("wr_only_in_done_cycle", 64'(d_done), 64'(1));
            end
            if (i_done || d_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
    endtask

    task automatic complete();
        exp_t e;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_empty: got done expected no done");
            return;
        end
        e = sb.pop_front();
        check("done_port", 64'({i_done, d_done}), 64'(e.is_d ? 2'b01 : 2'b10));
        check("done_addr", 64'(mem_addr), 64'(e.addr));
        check("done_wr", 64'(mem_wr), 64'(e.wr));
        if (e.wr) check("done_wdata", 64'(mem_wdata), 64'(e.wdata));
        if (!e.wr) begin
            if (e.is_d) exp_d_rd = memword(e.addr);
            else        exp_i_rd = memword(e.addr);
        end
    endtask

    task automatic check_rdata();
        check("i_rdata", 64'(i_rdata), 64'(exp_i_rd));
        check("d_rdata", 64'(d_rdata), 64'(exp_d_rd));
    endtask

    initial begin
        vec_t vt[6];
        int   cyc, ens, wrs;
        bit   ok;

        vt[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 4, 0};
        vt[1] = '{1'b1, 1'b1, 16'h0100, 16'h1234, 4, 1};
        vt[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 4, 0};
        vt[3] = '{1'b0, 1'b0, 16'h0FFE, 16'h0000, 4, 0};
        vt[4] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 4, 1};
        vt[5] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 4, 0};

        rst_n = 1'b0;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        d_req1 = 1'b0; d_addr1 = '0;
        exp_i_rd = '0; exp_d_rd = '0; exp_d_rd1 = '0;

        // Reset held with random inputs: everything must stay quiet.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_flags", 64'({i_done, d_done, mem_en, mem_wr, busy}), 64'(0));
            check("rst_data", {i_rdata, d_rdata, mem_addr, mem_wdata}, 64'(0));
            i_req = 1'($urandom); d_req = 1'($urandom); d_wr = 1'($urandom);
            i_addr = 16'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
        end
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            i_req = !vt[v].is_d; d_req = vt[v].is_d; d_wr = vt[v].wr;
            if (vt[v].is_d) d_addr = vt[v].addr; else i_addr = vt[v].addr;
            d_wdata = vt[v].wdata;
            sb.push_back('{vt[v].is_d, vt[v].wr, vt[v].addr, vt[v].wdata});
            wait_done(cyc, ens, wrs, ok);
            if (!ok) break;
            complete();
            check("latency", 64'(cyc), 64'(vt[v].exp_cycles));
            check("en_cycles", 64'(ens), 64'(vt[v].exp_cycles));
            check("wr_pulses", 64'(wrs), 64'(vt[v].exp_wr_pulses));
            @(posedge clk); #1;
            i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
            @(negedge clk);
            check_rdata();
            check("idle_busy", 64'({busy, mem_en}), 64'(0));
        end

        // Tie after reset: D, then I, then another tie goes to D, then I alone.
        sb.delete();
        rst_n = 1'b0; #2; rst_n = 1'b1;
        exp_i_rd = '0; exp_d_rd = '0;
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0200;
        d_req = 1'b1; d_addr = 16'h0300; d_wr = 1'b0;
        sb.push_back('{1'b1, 1'b0, 16'h0300, 16'h0000});
        sb.push_back('{1'b0, 1'b0, 16'h0200, 16'h0000});
        for (int s = 0; s < 4; s++) begin
            wait_done(cyc, ens, wrs, ok);
            if (!ok) break;
            complete();
            @(posedge clk); #1;
            case (s)
                0: begin d_addr = 16'h0302; sb.push_back('{1'b1, 1'b0, 16'h0302, 16'h0000}); end
                1: begin i_addr = 16'h0202; sb.push_back('{1'b0, 1'b0, 16'h0202, 16'h0000}); end
                2: d_req = 1'b0;
                default: i_req = 1'b0;
            endcase
            @(negedge clk);
            check_rdata();
        end
        check("tie_sb_drained", 64'(sb.size()), 64'(0));

        // Store aborted by reset during its second access cycle.
        i_req = 1'b0; d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        check("abort_en_c1", 64'({mem_en, mem_wr, d_done}), 64'(3'b100));
        @(posedge clk); #1;
        check("abort_c2_no_wr", 64'({mem_wr, d_done}), 64'(0));
        rst_n = 1'b0;
        #1;
        check("abort_en_drop", 64'({mem_en, busy, mem_wr, d_done}), 64'(0));
        d_req = 1'b0; d_wr = 1'b0;
        exp_i_rd = '0; exp_d_rd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("abort_quiet", 64'({mem_wr, d_done, mem_en, busy}), 64'(0));
        end
        check_rdata();

        // LATENCY=1 instance: back-to-back loads, done every second cycle.
        @(negedge clk);
        d_req1 = 1'b1; d_addr1 = 16'h0002;
        sb1.push_back(memword(16'h0002));
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("l1_done", 64'(d_done1), 64'(k % 2));
            check("l1_en", 64'(mem_en1), 64'(k % 2));
            if (d_done1) begin
                check("l1_wr", 64'(mem_wr1), 64'(0));
                check("l1_addr", 64'(mem_addr1), 64'(k == 1 ? 16'h0002 : 16'h0004));
                if (sb1.size() != 0) exp_d_rd1 = sb1.pop_front();
                @(posedge clk); #1;
                if (k == 1) begin
                    d_addr1 = 16'h0004;
                    sb1.push_back(memword(16'h0004));
                end else begin
                    d_req1 = 1'b0;
                end
            end else begin
                check("l1_rdata", 64'(d_rdata1), 64'(exp_d_rd1));
            end
        end
        @(negedge clk);
        check("l1_final_rdata", 64'(d_rdata1), 64'(memword(16'h0004)));
        check("l1_idle", 64'({busy1, d_done1, i_done1}), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
